// File: rtl/traffic_light_sequencer.sv
// Traffic light sequencer: red/green/yellow cycle with a BCD countdown
// and a flashing-yellow standby mode selected by the synchronised run_en.
module traffic_light_sequencer #(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int RED_SEC     = 30,
  parameter int GREEN_SEC   = 25,
  parameter int YELLOW_SEC  = 5
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST_N,
  input  logic       run_en,
  output logic [2:0] light,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       phase_start
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);

  localparam logic [3:0] RED_T = 4'(RED_SEC / 10);
  localparam logic [3:0] RED_O = 4'(RED_SEC % 10);
  localparam logic [3:0] GRN_T = 4'(GREEN_SEC / 10);
  localparam logic [3:0] GRN_O = 4'(GREEN_SEC % 10);
  localparam logic [3:0] YEL_T = 4'(YELLOW_SEC / 10);
  localparam logic [3:0] YEL_O = 4'(YELLOW_SEC % 10);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  if (TICK_CYCLES < 1) begin : g_bad_tick
    $error("TICK_CYCLES must be at least 1");
  end
  if (RED_SEC < 1 || RED_SEC > 99) begin : g_bad_red
    $error("RED_SEC must be in 1..99");
  end
  if (GREEN_SEC < 1 || GREEN_SEC > 99) begin : g_bad_green
    $error("GREEN_SEC must be in 1..99");
  end
  if (YELLOW_SEC < 1 || YELLOW_SEC > 99) begin : g_bad_yellow
    $error("YELLOW_SEC must be in 1..99");
  end

  typedef enum logic [1:0] {
    S_FLASH,
    S_RED,
    S_GREEN,
    S_YELLOW
  } state_e;

  logic          sync1_q;
  logic          run_s_q;
  logic          run_d_q;
  logic [PW-1:0] pcnt_q, pcnt_d;
  state_e        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          blink_q, blink_d;
  logic [2:0]    light_q, light_d;
  logic          ps_q, ps_d;

  logic mode_chg;
  logic sec_tick;
  logic is_flash;
  logic bcd_one;

  always_comb begin
    mode_chg = run_s_q ^ run_d_q;
    sec_tick = (pcnt_q == PMAX);
    is_flash = (state_q == S_FLASH);
    bcd_one  = (tens_q == 4'd0) && (ones_q == 4'd1);
    // A mode change restarts the second so each mode opens with a full one
    pcnt_d   = (mode_chg || sec_tick) ? '0 : pcnt_q + 1'b1;
    state_d  = state_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    blink_d  = blink_q;
    ps_d     = 1'b0;

    unique case (1'b1)
      (!run_s_q && !is_flash): begin
        state_d = S_FLASH;
        blink_d = 1'b1;
        tens_d  = 4'd0;
        ones_d  = 4'd0;
      end
      (run_s_q && is_flash): begin
        state_d = S_RED;
        tens_d  = RED_T;
        ones_d  = RED_O;
        ps_d    = 1'b1;
      end
      (run_s_q && !is_flash && sec_tick && bcd_one): begin
        ps_d = 1'b1;
        case (state_q)
          S_RED: begin
            state_d = S_GREEN;
            tens_d  = GRN_T;
            ones_d  = GRN_O;
          end
          S_GREEN: begin
            state_d = S_YELLOW;
            tens_d  = YEL_T;
            ones_d  = YEL_O;
          end
          default: begin
            state_d = S_RED;
            tens_d  = RED_T;
            ones_d  = RED_O;
          end
        endcase
      end
      (run_s_q && !is_flash && sec_tick && !bcd_one): begin
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 1'b1;
        end else begin
          ones_d = ones_q - 1'b1;
        end
      end
      (!run_s_q && is_flash && sec_tick): begin
        blink_d = ~blink_q;
      end
      default: ;
    endcase

    case (state_d)
      S_RED:    light_d = L_RED;
      S_GREEN:  light_d = L_GRN;
      S_YELLOW: light_d = L_YEL;
      default:  light_d = {1'b0, blink_d, 1'b0};
    endcase
  end

  always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
    if (!Sys_RST_N) begin
      sync1_q <= 1'b0;
      run_s_q <= 1'b0;
      run_d_q <= 1'b0;
      pcnt_q  <= '0;
      state_q <= S_RED;
      tens_q  <= RED_T;
      ones_q  <= RED_O;
      blink_q <= 1'b0;
      light_q <= L_RED;
      ps_q    <= 1'b0;
    end else begin
      sync1_q <= run_en;
      run_s_q <= sync1_q;
      run_d_q <= run_s_q;
      pcnt_q  <= pcnt_d;
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      blink_q <= blink_d;
      light_q <= light_d;
      ps_q    <= ps_d;
    end
  end

  assign light       = light_q;
  assign cnt_tens    = tens_q;
  assign cnt_ones    = ones_q;
  assign phase_start = ps_q;

endmodule
